// File: rtl/pulse_sched_ctrl.sv
// Spin-echo frame scheduler: staged timing registers, per-frame commit, Sync/Pulse/P2 sequencing.
// Optional CPMG echo train (multiple P2 pulses) enabled by defining PULSE_SCHED_CPMG_EN.
`timescale 1ns/1ps
module pulse_sched_ctrl #(
  parameter int CW       = 32,
  parameter int SYNC_LEN = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          wr_en,
  input  logic [2:0]    wr_addr,
  input  logic [CW-1:0] wr_data,
  output logic          Sync,
  output logic          Pulse,
  output logic          P2,
  output logic          busy,
  output logic          done,
  output logic          cfg_err
);

  // state  | meaning
  // S_IDLE | no frame; waiting for run with a valid config
  // S_P1   | first (pi/2) pulse
  // S_DLY  | low gap before a P2 pulse
  // S_P2   | second (pi) pulse
  // S_WAIT | low until the last frame cycle
  typedef enum logic [2:0] {S_IDLE, S_P1, S_DLY, S_P2, S_WAIT} state_t;

`ifdef PULSE_SCHED_CPMG_EN
  localparam int SW = 2*CW + 4;
`else
  localparam int SW = CW + 2;
`endif
  localparam int SG = CW + 1;

  state_t state_q, state_d;
  logic [CW-1:0] fc_q, fc_d;
  logic [SG-1:0] seg_q, seg_d;
  logic [CW-1:0] cnt_q, cnt_d;

  logic [CW-1:0] stg_per_q, stg_per_d, stg_p1_q, stg_p1_d;
  logic [CW-1:0] stg_dly_q, stg_dly_d, stg_p2_q, stg_p2_d;
`ifdef PULSE_SCHED_CPMG_EN
  logic [CW-1:0] stg_n_q, stg_n_d, n_nxt;
`endif
  logic [CW-1:0] act_per_q, act_dly_q, act_p2_q;
  logic          run_q, run_pre, run_d, single_q, single_d;
  logic          cfg_err_q, cfg_err_d;
  logic          sync_q, pulse_q, p2_q, busy_q, done_q;
  logic [SW-1:0] tot;
  logic          valid, last, decide, start;

  // Staged values including this cycle's write, so a write on a start cycle takes effect.
  always_comb begin
    stg_per_d = stg_per_q;
    stg_p1_d  = stg_p1_q;
    stg_dly_d = stg_dly_q;
    stg_p2_d  = stg_p2_q;
`ifdef PULSE_SCHED_CPMG_EN
    stg_n_d   = stg_n_q;
`endif
    run_pre   = run_q;
    single_d  = single_q;
    if (wr_en) begin
      case (wr_addr)
        3'd0: stg_per_d = wr_data;
        3'd1: stg_p1_d  = wr_data;
        3'd2: stg_dly_d = wr_data;
        3'd3: stg_p2_d  = wr_data;
        3'd4: begin
          run_pre  = wr_data[0];
          single_d = wr_data[1];
        end
`ifdef PULSE_SCHED_CPMG_EN
        3'd5: stg_n_d = wr_data;
`endif
        default: ;
      endcase
    end
  end

`ifdef PULSE_SCHED_CPMG_EN
  assign n_nxt = (stg_n_d == '0) ? CW'(1) : stg_n_d;
  assign tot = SW'(stg_p1_d) + SW'(stg_dly_d) + SW'(n_nxt) * SW'(stg_p2_d)
             + (SW'(n_nxt) - SW'(1)) * SW'(stg_dly_d) * SW'(2);
`else
  assign tot = SW'(stg_p1_d) + SW'(stg_dly_d) + SW'(stg_p2_d);
`endif
  assign valid = (stg_per_d >= CW'(2)) && (stg_p1_d != '0) && (tot < SW'(stg_per_d));

  always_comb begin
    state_d   = state_q;
    fc_d      = fc_q;
    seg_d     = seg_q;
    cnt_d     = cnt_q;
    last      = (state_q != S_IDLE) && (fc_q == act_per_q - CW'(1));
    decide    = (state_q == S_IDLE) || last;
    start     = decide && run_pre && valid;
    run_d     = (start && single_d) ? 1'b0 : run_pre;
    cfg_err_d = (decide && run_pre) ? !valid : cfg_err_q;
    if (start) begin
      state_d = S_P1;
      fc_d    = '0;
      seg_d   = {1'b0, stg_p1_d - CW'(1)};
`ifdef PULSE_SCHED_CPMG_EN
      cnt_d   = n_nxt - CW'(1);
`else
      cnt_d   = '0;
`endif
    end else if (last) begin
      state_d = S_IDLE;
      fc_d    = '0;
    end else if (state_q != S_IDLE) begin
      fc_d = fc_q + CW'(1);
      if (seg_q != '0) seg_d = seg_q - SG'(1);
      // seg_q is the down-counted remainder of the current segment; zero means its last cycle.
      case (state_q)
        S_P1, S_DLY: begin
          if (seg_q == '0) begin
            if (state_q == S_P1 && act_dly_q != '0) begin
              state_d = S_DLY;
              seg_d   = {1'b0, act_dly_q - CW'(1)};
            end else if (act_p2_q != '0) begin
              state_d = S_P2;
              seg_d   = {1'b0, act_p2_q - CW'(1)};
            end else begin
              state_d = S_WAIT;
            end
          end
        end
        S_P2: begin
          if (seg_q == '0) begin
            if (cnt_q != '0) begin
              cnt_d = cnt_q - CW'(1);
              if (act_dly_q != '0) begin
                state_d = S_DLY;
                seg_d   = {act_dly_q, 1'b0} - SG'(1);
              end else begin
                seg_d   = {1'b0, act_p2_q - CW'(1)};
              end
            end else begin
              state_d = S_WAIT;
            end
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      fc_q      <= '0;
      seg_q     <= '0;
      cnt_q     <= '0;
      stg_per_q <= '0;
      stg_p1_q  <= '0;
      stg_dly_q <= '0;
      stg_p2_q  <= '0;
`ifdef PULSE_SCHED_CPMG_EN
      stg_n_q   <= '0;
`endif
      act_per_q <= '0;
      act_dly_q <= '0;
      act_p2_q  <= '0;
      run_q     <= 1'b0;
      single_q  <= 1'b0;
      cfg_err_q <= 1'b0;
      sync_q    <= 1'b0;
      pulse_q   <= 1'b0;
      p2_q      <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      fc_q      <= fc_d;
      seg_q     <= seg_d;
      cnt_q     <= cnt_d;
      stg_per_q <= stg_per_d;
      stg_p1_q  <= stg_p1_d;
      stg_dly_q <= stg_dly_d;
      stg_p2_q  <= stg_p2_d;
`ifdef PULSE_SCHED_CPMG_EN
      stg_n_q   <= stg_n_d;
`endif
      if (start) begin
        act_per_q <= stg_per_d;
        act_dly_q <= stg_dly_d;
        act_p2_q  <= stg_p2_d;
      end
      run_q     <= run_d;
      single_q  <= single_d;
      cfg_err_q <= cfg_err_d;
      sync_q    <= (state_q != S_IDLE) && (fc_q < CW'(SYNC_LEN));
      pulse_q   <= (state_q == S_P1);
      p2_q      <= (state_q == S_P2);
      busy_q    <= (state_q != S_IDLE);
      done_q    <= last;
    end
  end

  assign Sync    = sync_q;
  assign Pulse   = pulse_q;
  assign P2      = p2_q;
  assign busy    = busy_q;
  assign done    = done_q;
  assign cfg_err = cfg_err_q;

endmodule

// File: tb/tb_pulse_sched_ctrl.sv
// Directed bench for pulse_sched_ctrl; frame positions are measured from the observed Sync rise.
`timescale 1ns/1ps
module tb_pulse_sched_ctrl;
  localparam int CW = 32;

  logic          clk = 1'b0;
  logic          reset, wr_en;
  logic [2:0]    wr_addr;
  logic [CW-1:0] wr_data;
  logic          Sync, Pulse, P2, busy, done, cfg_err;
  int            total = 0;
  int            bad = 0;
  int            s;
  logic [255:0]  sy_tr, pu_tr, p2_tr, bu_tr, dn_tr;

  always #5 clk = ~clk;

  pulse_sched_ctrl #(.CW(CW), .SYNC_LEN(4)) dut (
    .clk(clk), .reset(reset), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .Sync(Sync), .Pulse(Pulse), .P2(P2), .busy(busy), .done(done), .cfg_err(cfg_err)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic wr(input logic [2:0] a, input logic [CW-1:0] d);
    @(posedge clk); #1;
    wr_en = 1'b1; wr_addr = a; wr_data = d;
    @(posedge clk); #1;
    wr_en = 1'b0;
  endtask

  // Sample n cycles at negedge; optionally issue one write right after sample wk.
  task automatic capture(input int n, input int wk, input logic [2:0] wa, input logic [CW-1:0] wd);
    sy_tr = '0; pu_tr = '0; p2_tr = '0; bu_tr = '0; dn_tr = '0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      sy_tr[i] = Sync; pu_tr[i] = Pulse; p2_tr[i] = P2; bu_tr[i] = busy; dn_tr[i] = done;
      if (i == wk) begin
        wr_en = 1'b1; wr_addr = wa; wr_data = wd;
      end else if (i == wk + 1) begin
        wr_en = 1'b0;
      end
    end
    wr_en = 1'b0;
  endtask

  task automatic wait_rise(input string tag);
    logic prev;
    bit   got;
    prev = 1'b1;
    got  = 1'b0;
    for (int k = 0; k < 60 && !got; k++) begin
      @(negedge clk);
      if (Sync === 1'b1 && prev === 1'b0) got = 1'b1;
      prev = Sync;
    end
    chk(tag, 64'(got), 64'd1);
  endtask

  function automatic int first_rise(input logic [255:0] v, input int n);
    for (int i = 1; i < n; i++) if (v[i] && !v[i-1]) return i;
    return -1;
  endfunction

  function automatic logic [63:0] win(input logic [255:0] v, input int st, input int w);
    logic [255:0] t;
    t = v >> st;
    return t[63:0] & ((64'd1 << w) - 64'd1);
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_outs", 64'({Sync, Pulse, P2, busy, done, cfg_err}), 64'd0);
    @(posedge clk); #1 reset = 1'b0;

    // 1: basic frame timing and back-to-back frames
    wr(3'd0, 20); wr(3'd1, 3); wr(3'd2, 4); wr(3'd3, 5); wr(3'd4, 1);
    capture(60, -5, 3'd0, '0);
    s = first_rise(sy_tr, 60);
    chk("t1_found", 64'(s >= 0), 64'd1);
    if (s < 0) s = 0;
    chk("t1_pulse", win(pu_tr, s, 20), 64'h00007);
    chk("t1_p2",    win(p2_tr, s, 20), 64'h00F80);
    chk("t1_sync",  win(sy_tr, s, 20), 64'h0000F);
    chk("t1_done",  win(dn_tr, s, 20), 64'h80000);
    chk("t1_busy",  win(bu_tr, s, 20), 64'hFFFFF);
    chk("t1_nogap", win(sy_tr, s + 20, 4), 64'hF);
    chk("t1_cfgerr", 64'(cfg_err), 64'd0);

    // 4: p2 rewritten at fc5 affects only the next frame
    wait_rise("t4_rise");
    capture(40, 4, 3'd3, 2);
    chk("t4_cur_p2",  win(p2_tr, 0, 19), 64'h007C0);
    chk("t4_nxt_sync", win(sy_tr, 19, 4), 64'hF);
    chk("t4_nxt_p2",  win(p2_tr, 19, 20), 64'h00180);

    // run cleared mid-frame: frame completes, then idle
    wait_rise("stop_rise");
    capture(40, 2, 3'd4, 0);
    chk("stop_busy", win(bu_tr, 0, 19), 64'h7FFFF);
    chk("stop_done", win(dn_tr, 0, 19), 64'h40000);
    chk("stop_idle", win(bu_tr, 19, 21) | win(sy_tr, 19, 21), 64'd0);

    // 3: single shot
    wr(3'd3, 5); wr(3'd4, 3);
    capture(60, -5, 3'd0, '0);
    s = first_rise(sy_tr, 60);
    chk("t3_found", 64'(s >= 0), 64'd1);
    if (s < 0) s = 0;
    chk("t3_ndone", 64'($countones(dn_tr)), 64'd1);
    chk("t3_nbusy", 64'($countones(bu_tr)), 64'd20);
    chk("t3_done",  win(dn_tr, s, 20), 64'h80000);
    capture(30, -5, 3'd0, '0);
    chk("t3_runclr", 64'($countones(bu_tr)), 64'd0);

    // 2: invalid config rejected, then fixed by a period write
    wr(3'd0, 10); wr(3'd4, 1);
    capture(20, -5, 3'd0, '0);
    chk("t2_quiet", 64'($countones(bu_tr) + $countones(sy_tr) + $countones(pu_tr) + $countones(p2_tr)), 64'd0);
    chk("t2_err", 64'(cfg_err), 64'd1);
    wr(3'd0, 20);
    capture(40, -5, 3'd0, '0);
    chk("t2_errclr", 64'(cfg_err), 64'd0);
    s = first_rise(sy_tr, 40);
    chk("t2_found", 64'(s >= 0), 64'd1);
    if (s < 0) s = 0;
    chk("t2_pulse", win(pu_tr, s, 20), 64'h00007);
    chk("t2_p2",    win(p2_tr, s, 20), 64'h00F80);

    // 5: reset at fc8 mid-frame
    wait_rise("t5_rise");
    repeat (7) @(negedge clk);
    chk("t5_fc7_p2", 64'(P2), 64'd1);
    @(negedge clk); reset = 1'b1;
    @(negedge clk);
    chk("t5_outs0", 64'({Sync, Pulse, P2, busy, done, cfg_err}), 64'd0);
    @(negedge clk); reset = 1'b0;
    capture(30, -5, 3'd0, '0);
    chk("t5_quiet", 64'($countones(bu_tr) + $countones(sy_tr) + $countones(pu_tr) + $countones(p2_tr)), 64'd0);

    // 6: CPMG train (single P2 when the option is not built)
    wr(3'd0, 60); wr(3'd1, 2); wr(3'd2, 3); wr(3'd3, 2); wr(3'd5, 3); wr(3'd4, 3);
    capture(80, -5, 3'd0, '0);
    s = first_rise(sy_tr, 80);
    chk("t6_found", 64'(s >= 0), 64'd1);
    if (s < 0) s = 0;
    chk("t6_pulse", win(pu_tr, s, 60), 64'h3);
    chk("t6_ndone", 64'($countones(dn_tr)), 64'd1);
`ifdef PULSE_SCHED_CPMG_EN
    chk("t6_p2", win(p2_tr, s, 60), 64'h606060);
`else
    chk("t6_p2", win(p2_tr, s, 60), 64'h60);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
